spi_mem_arbiter: RTL and testbench
==================================

SPI_MEM_ARBITER -- requirements
Module: spi_mem_arbiter

Interface
REQ-001 Parameter DIV, default 1: SCK half-period in wb_clk cycles; legal range 1..255.
REQ-002 Parameter (none else); SPI memory is 23LC512-class, 16-bit address, sequential mode.
REQ-003 wb_clk  in  1  single clock; all logic on rising edge.
REQ-004 wb_rst  in  1  reset, synchronous, active-high.
REQ-005 i_ibus_adr  in  32  instruction fetch byte address; i_ibus_cyc  in  1  fetch request; o_ibus_rdt  out  32  fetch data; o_ibus_ack  out  1  one-cycle completion pulse.
REQ-006 i_dbus_adr  in  32; i_dbus_dat  in  32  write data; i_dbus_sel  in  4  byte enables; i_dbus_we  in  1; i_dbus_cyc  in  1; o_dbus_rdt  out  32; o_dbus_ack  out  1.
REQ-007 o_spi_sck  out  1; o_spi_ss  out  1 (active-low); o_spi_mosi  out  1; i_spi_miso  in  1.

Function
REQ-008 All outputs SHALL be registered.
REQ-009 FSM states: IDLE, SHIFT, DONE, GAP.
REQ-010 IDLE: if any cyc high, SHALL grant one requester, latch its address/data/sel/we, go SHIFT; o_spi_ss low from next cycle.
REQ-011 Arbitration SHALL be round-robin: simultaneous requests -> grant requester not granted last; pointer favours ibus after reset.
REQ-012 Frame: 8-bit command, 16-bit address, N data bytes; every byte MSB first; SPI mode 0.
REQ-013 Command SHALL be 0x03 for ibus and dbus reads, 0x02 for dbus writes.
REQ-014 Reads: address = {adr[15:2],2'b00}, N=4; byte k received SHALL land in rdt[8k+7:8k].
REQ-015 Writes: address = adr[15:0] with [1:0] = index of lowest set sel bit; N = (highest set index - lowest set index + 1); bytes sent lowest first from i_dbus_dat lanes; non-contiguous sel writes the full span.
REQ-016 Each bit SHALL occupy 2*DIV cycles: DIV cycles SCK low then DIV cycles SCK high; MOSI updates at start of low phase; MISO sampled in cycle SCK rises.
REQ-017 MOSI SHALL be 0 when SS high and during read data bytes.
REQ-018 DONE: after last high phase, SCK low, SS high, granted ack pulses one cycle with rdt valid; ack latency = 1 + 2*DIV*(24+8N) cycles after the IDLE grant cycle.
REQ-019 GAP: one cycle, SS high, no grant (absorbs requester cyc still high after ack); then IDLE; SS high minimum 3 cycles between frames.
REQ-020 dbus write with sel=4'b0000 SHALL issue no frame; ack one cycle after grant; SS stays high.
REQ-021 Address bits [31:16] SHALL be ignored (64 KiB alias).
REQ-022 cyc deasserted mid-frame: frame completes and ack still pulses.
REQ-023 o_ibus_rdt/o_dbus_rdt SHALL hold last value until next read ack of that port.

Reset
REQ-024 wb_rst high SHALL force next cycle: IDLE, o_spi_ss=1, o_spi_sck=0, o_spi_mosi=0, both acks 0, both rdt 0, RR pointer to ibus.
REQ-025 Reset mid-frame SHALL abort without ack; first request after release starts a fresh frame.

Verification
REQ-026 DIV=1, ibus read adr 0x0000_1234, SPI model returns 0x11,0x22,0x33,0x44 -> MOSI 0x03,0x12,0x34; o_ibus_rdt=0x44332211; ack 113 cycles after grant.
REQ-027 dbus write adr 0x0000_0100, sel 4'b1100, dat 0xAABBCCDD -> MOSI 0x02,0x01,0x02,0xBB,0xAA; 40 SCK rises; ack at cycle 81.
REQ-028 ibus and dbus cyc asserted same cycle after reset -> ibus served first, dbus next; repeat -> dbus first.
REQ-029 dbus we=1, sel=0 -> no SS low; o_dbus_ack one cycle after grant.
REQ-030 DIV=3, dbus read -> SCK period 6 cycles, ack at 1+6*56=337.
REQ-031 wb_rst asserted at bit 10 of frame -> SS high, SCK low next cycle, no ack; subsequent read correct.

Source files
------------

// File: rtl/spi_mem_arbiter.sv
// Shares one 23LC512-class SPI SRAM between an instruction-fetch bus and a data bus.
// Round-robin grant, one sequential-mode frame per access, registered outputs.
module spi_mem_arbiter #(
  parameter int unsigned DIV = 1
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic        o_spi_sck,
  output logic        o_spi_ss,
  output logic        o_spi_mosi,
  input  logic        i_spi_miso
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;
  localparam logic [7:0] DIV_M1  = 8'(DIV - 1);

  logic [1:0]  r_state;
  logic        r_last_dbus;
  logic        r_owner_d;
  logic        r_is_read;
  logic [55:0] r_tx;
  logic [31:0] r_rx;
  logic [5:0]  r_last_bit;
  logic [5:0]  r_bit_cnt;
  logic [7:0]  r_div_cnt;
  logic        r_phase;
  logic        r_sck;
  logic        r_ss;
  logic        r_mosi;
  logic        r_ibus_ack;
  logic        r_dbus_ack;
  logic [31:0] r_ibus_rdt;
  logic [31:0] r_dbus_rdt;

  logic        w_gnt_d;
  logic        w_wr;
  logic        w_empty_wr;
  logic [1:0]  w_lo;
  logic [1:0]  w_hi;
  logic [2:0]  w_nbytes;
  logic [15:2] w_adr;
  logic [15:0] w_frame_adr;
  logic [31:0] w_shdat;
  logic [31:0] w_wdata;
  logic [55:0] w_frame;
  logic [5:0]  w_last_bit;
  logic        w_sample;
  logic        w_div_end;
  logic        w_frame_end;
  logic [31:0] w_rx_next;
  logic [31:0] w_rx_cur;
  logic [31:0] w_rdt_new;
  logic        w_unused;

  // dbus wins a tie only when ibus held the previous grant
  assign w_gnt_d    = i_dbus_cyc & (~i_ibus_cyc | ~r_last_dbus);
  assign w_wr       = w_gnt_d & i_dbus_we;
  assign w_empty_wr = w_wr & (i_dbus_sel == 4'b0000);

  always_comb begin
    w_lo = '0;
    w_hi = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      if (i_dbus_sel[i-1]) w_lo = 2'(i - 1);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      if (i_dbus_sel[i]) w_hi = 2'(i);
    end
  end

  assign w_nbytes    = w_wr ? ({1'b0, w_hi} - {1'b0, w_lo} + 3'd1) : 3'd4;
  assign w_adr       = w_gnt_d ? i_dbus_adr[15:2] : i_ibus_adr[15:2];
  assign w_frame_adr = {w_adr, (w_wr ? w_lo : 2'b00)};
  assign w_shdat     = i_dbus_dat >> {w_lo, 3'b000};
  assign w_wdata     = w_wr ? {w_shdat[7:0], w_shdat[15:8], w_shdat[23:16], w_shdat[31:24]} : '0;
  assign w_frame     = {(w_wr ? 8'h02 : 8'h03), w_frame_adr, w_wdata};
  assign w_last_bit  = {w_nbytes, 3'b000} + 6'd23;

  // With DIV=1 the sampling cycle is also the frame's final cycle, so the
  // read data is built from the not-yet-registered shift value.
  assign w_div_end   = (r_div_cnt == DIV_M1);
  assign w_sample    = (r_state == S_SHIFT) & r_phase & (r_div_cnt == '0);
  assign w_frame_end = r_phase & w_div_end & (r_bit_cnt == r_last_bit);
  assign w_rx_next   = {r_rx[30:0], i_spi_miso};
  assign w_rx_cur    = w_sample ? w_rx_next : r_rx;
  assign w_rdt_new   = {w_rx_cur[7:0], w_rx_cur[15:8], w_rx_cur[23:16], w_rx_cur[31:24]};

  assign w_unused = &{1'b0, i_ibus_adr[31:16], i_ibus_adr[1:0], i_dbus_adr[31:16], i_dbus_adr[1:0]};

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_state     <= S_IDLE;
      r_last_dbus <= 1'b1;
      r_owner_d   <= 1'b0;
      r_is_read   <= 1'b0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_last_bit  <= '0;
      r_bit_cnt   <= '0;
      r_div_cnt   <= '0;
      r_phase     <= 1'b0;
      r_sck       <= 1'b0;
      r_ss        <= 1'b1;
      r_mosi      <= 1'b0;
      r_ibus_ack  <= 1'b0;
      r_dbus_ack  <= 1'b0;
      r_ibus_rdt  <= '0;
      r_dbus_rdt  <= '0;
    end else begin
      r_ibus_ack <= 1'b0;
      r_dbus_ack <= 1'b0;
      if (w_sample) r_rx <= w_rx_next;
      case (r_state)
        S_IDLE: begin
          if (i_ibus_cyc | i_dbus_cyc) begin
            r_last_dbus <= w_gnt_d;
            r_owner_d   <= w_gnt_d;
            r_is_read   <= ~w_wr;
            if (w_empty_wr) begin
              r_state    <= S_DONE;
              r_dbus_ack <= 1'b1;
            end else begin
              r_state    <= S_SHIFT;
              r_ss       <= 1'b0;
              r_mosi     <= w_frame[55];
              r_tx       <= {w_frame[54:0], 1'b0};
              r_last_bit <= w_last_bit;
              r_bit_cnt  <= '0;
              r_div_cnt  <= '0;
              r_phase    <= 1'b0;
            end
          end
        end
        S_SHIFT: begin
          if (!w_div_end) begin
            r_div_cnt <= r_div_cnt + 8'd1;
          end else begin
            r_div_cnt <= '0;
            if (!r_phase) begin
              r_phase <= 1'b1;
              r_sck   <= 1'b1;
            end else if (w_frame_end) begin
              r_state    <= S_DONE;
              r_sck      <= 1'b0;
              r_ss       <= 1'b1;
              r_mosi     <= 1'b0;
              r_ibus_ack <= ~r_owner_d;
              r_dbus_ack <= r_owner_d;
              if (r_is_read && !r_owner_d) r_ibus_rdt <= w_rdt_new;
              if (r_is_read && r_owner_d)  r_dbus_rdt <= w_rdt_new;
            end else begin
              r_phase   <= 1'b0;
              r_sck     <= 1'b0;
              r_mosi    <= r_tx[55];
              r_tx      <= {r_tx[54:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 6'd1;
            end
          end
        end
        S_DONE:  r_state <= S_GAP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ibus_rdt = r_ibus_rdt;
  assign o_ibus_ack = r_ibus_ack;
  assign o_dbus_rdt = r_dbus_rdt;
  assign o_dbus_ack = r_dbus_ack;
  assign o_spi_sck  = r_sck;
  assign o_spi_ss   = r_ss;
  assign o_spi_mosi = r_mosi;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Scoreboard bench for spi_mem_arbiter: a 23LC512-style SPI SRAM model, expected acks
// queued by the stimulus and checked by a negedge monitor. Two DUTs: DIV=1 and DIV=3.
module tb_spi_mem_arbiter;

  typedef struct {
    int unsigned cyc;
    logic [31:0] rdt;
    int          nb;
    logic [55:0] bytes;
    int          rises;
    int          ssf;
  } exp_t;

  logic clk = 1'b0;
  logic wb_rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cycnt = 0;
  always @(posedge clk) cycnt <= cycnt + 1;

  logic [31:0] i1_adr = '0, d1_adr = '0, d1_dat = '0;
  logic [3:0]  d1_sel = '0;
  logic        i1_cyc = 1'b0, d1_cyc = 1'b0, d1_we = 1'b0;
  logic [31:0] i1_rdt, d1_rdt;
  logic        i1_ack, d1_ack, sck1, ss1, mosi1;

  logic [31:0] i3_adr = '0, d3_adr = '0, d3_dat = '0;
  logic [3:0]  d3_sel = '0;
  logic        i3_cyc = 1'b0, d3_cyc = 1'b0, d3_we = 1'b0;
  logic [31:0] i3_rdt, d3_rdt;
  logic        i3_ack, d3_ack, sck3, ss3, mosi3;

  logic miso = 1'b0;

  spi_mem_arbiter #(.DIV(1)) u_dut1 (
    .wb_clk(clk), .wb_rst(wb_rst),
    .i_ibus_adr(i1_adr), .i_ibus_cyc(i1_cyc), .o_ibus_rdt(i1_rdt), .o_ibus_ack(i1_ack),
    .i_dbus_adr(d1_adr), .i_dbus_dat(d1_dat), .i_dbus_sel(d1_sel), .i_dbus_we(d1_we),
    .i_dbus_cyc(d1_cyc), .o_dbus_rdt(d1_rdt), .o_dbus_ack(d1_ack),
    .o_spi_sck(sck1), .o_spi_ss(ss1), .o_spi_mosi(mosi1), .i_spi_miso(miso)
  );

  spi_mem_arbiter #(.DIV(3)) u_dut3 (
    .wb_clk(clk), .wb_rst(wb_rst),
    .i_ibus_adr(i3_adr), .i_ibus_cyc(i3_cyc), .o_ibus_rdt(i3_rdt), .o_ibus_ack(i3_ack),
    .i_dbus_adr(d3_adr), .i_dbus_dat(d3_dat), .i_dbus_sel(d3_sel), .i_dbus_we(d3_we),
    .i_dbus_cyc(d3_cyc), .o_dbus_rdt(d3_rdt), .o_dbus_ack(d3_ack),
    .o_spi_sck(sck3), .o_spi_ss(ss3), .o_spi_mosi(mosi3), .i_spi_miso(miso)
  );

  // Only one DUT is active at a time; the idle one holds SS high, SCK/MOSI low.
  wire w_sck  = sck1 | sck3;
  wire w_ss   = ss1 & ss3;
  wire w_mosi = mosi1 | mosi3;

  logic [7:0]  mem [0:65535];
  int unsigned bitc = 0;
  logic [7:0]  sr = '0, s_cmd = '0;
  logic [15:0] s_addr = '0;
  int          sck_rises = 0, ss_falls = 0;
  logic [7:0]  mosi_log[$];

  always @(negedge w_ss) begin
    bitc = 0;
    sck_rises = 0;
    mosi_log.delete();
    ss_falls++;
  end

  always @(posedge w_sck) begin
    sck_rises++;
    if (!w_ss) begin
      sr = {sr[6:0], w_mosi};
      bitc++;
      if (bitc % 8 == 0) begin
        mosi_log.push_back(sr);
        if (bitc == 8) s_cmd = sr;
        else if (bitc == 16) s_addr[15:8] = sr;
        else if (bitc == 24) s_addr[7:0] = sr;
        else if (s_cmd == 8'h02) mem[s_addr + 16'((bitc - 32) / 8)] = sr;
      end
    end
  end

  always @(negedge w_sck) begin
    if (!w_ss && bitc >= 24 && s_cmd == 8'h03) begin
      logic [7:0] b;
      int unsigned off;
      off  = bitc - 24;
      b    = mem[s_addr + 16'(off / 8)];
      miso = b[7 - (off % 8)];
    end
  end

  int vectors = 0;
  int miscompares = 0;
  exp_t q_i1[$], q_d1[$], q_d3[$];

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_ack(input string nm, input exp_t e, input logic [31:0] rdt);
    cmp({nm, "_ack_cycle"}, 64'(cycnt), 64'(e.cyc));
    cmp({nm, "_rdt"}, 64'(rdt), 64'(e.rdt));
    cmp({nm, "_mosi_bytes"}, 64'(mosi_log.size()), 64'(e.nb));
    for (int j = 0; j < e.nb && j < mosi_log.size(); j++)
      cmp($sformatf("%s_mosi[%0d]", nm, j), 64'(mosi_log[j]), 64'(e.bytes[55 - 8*j -: 8]));
    cmp({nm, "_sck_rises"}, 64'(sck_rises), 64'(e.rises));
    cmp({nm, "_ss_falls"}, 64'(ss_falls), 64'(e.ssf));
  endtask

  task automatic unexpected(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s_unexpected_ack: got ack expected none", nm);
  endtask

  always @(negedge clk) begin
    if (i1_ack) begin
      if (q_i1.size() == 0) unexpected("u1_ibus");
      else check_ack("u1_ibus", q_i1.pop_front(), i1_rdt);
    end
    if (d1_ack) begin
      if (q_d1.size() == 0) unexpected("u1_dbus");
      else check_ack("u1_dbus", q_d1.pop_front(), d1_rdt);
    end
    if (d3_ack) begin
      if (q_d3.size() == 0) unexpected("u3_dbus");
      else check_ack("u3_dbus", q_d3.pop_front(), d3_rdt);
    end
    if (i3_ack) unexpected("u3_ibus");
  end

  function automatic exp_t mk(input int unsigned cyc, input logic [31:0] rdt, input int nb,
                              input logic [55:0] bytes, input int rises, input int ssf);
    exp_t e;
    e.cyc = cyc; e.rdt = rdt; e.nb = nb; e.bytes = bytes; e.rises = rises; e.ssf = ssf;
    return e;
  endfunction

  // One access on a single port: request, queue expectation, hold cyc through GAP, release.
  task automatic run(input bit on3, input bit is_d, input bit we, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [3:0] sel, input int unsigned lat,
                     input logic [31:0] rdt, input int nb, input logic [55:0] bytes,
                     input int rises, input int ssf);
    int unsigned c;
    @(posedge clk); #1;
    mosi_log.delete();
    sck_rises = 0;
    ss_falls  = 0;
    c = cycnt;
    if (on3) begin
      d3_adr = adr; d3_dat = dat; d3_sel = sel; d3_we = we; d3_cyc = 1'b1;
      q_d3.push_back(mk(c + lat, rdt, nb, bytes, rises, ssf));
    end else if (is_d) begin
      d1_adr = adr; d1_dat = dat; d1_sel = sel; d1_we = we; d1_cyc = 1'b1;
      q_d1.push_back(mk(c + lat, rdt, nb, bytes, rises, ssf));
    end else begin
      i1_adr = adr; i1_cyc = 1'b1;
      q_i1.push_back(mk(c + lat, rdt, nb, bytes, rises, ssf));
    end
    repeat (lat + 1) @(posedge clk);
    #1;
    d1_cyc = 1'b0; i1_cyc = 1'b0; d3_cyc = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int unsigned c;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h1234] = 8'h11; mem[16'h1235] = 8'h22; mem[16'h1236] = 8'h33; mem[16'h1237] = 8'h44;
    mem[16'h0100] = 8'h5A; mem[16'h0101] = 8'hC3;

    repeat (3) @(posedge clk);
    #1;
    cmp("rst_ss", 64'(ss1), 64'(1));
    cmp("rst_sck", 64'(sck1), 64'(0));
    cmp("rst_mosi", 64'(mosi1), 64'(0));
    cmp("rst_acks", 64'({i1_ack, d1_ack, i3_ack, d3_ack}), 64'(0));
    cmp("rst_rdt_i", 64'(i1_rdt), 64'(0));
    cmp("rst_rdt_d", 64'(d1_rdt), 64'(0));
    cmp("rst_ss3", 64'(ss3), 64'(1));
    wb_rst = 1'b0;
    repeat (2) @(posedge clk);

    run(0, 0, 0, 32'h0000_1234, '0, 4'h0, 113, 32'h4433_2211, 7, 56'h03_1234_00000000, 56, 1);
    run(0, 1, 1, 32'h0000_0100, 32'hAABB_CCDD, 4'b1100, 81, 32'h0, 5, 56'h02_0102_BBAA_0000, 40, 1);
    run(0, 1, 0, 32'hFFFF_0100, '0, 4'hF, 113, 32'hAABB_C35A, 7, 56'h03_0100_00000000, 56, 1);
    run(0, 1, 1, 32'h0000_0400, 32'h1234_5678, 4'b0000, 1, 32'hAABB_C35A, 0, 56'h0, 0, 0);
    run(0, 1, 1, 32'h0000_0200, 32'h1122_3344, 4'b1001, 113, 32'hAABB_C35A, 7, 56'h02_0200_44332211, 56, 1);
    run(0, 1, 1, 32'h0000_0300, 32'h00EE_0000, 4'b0100, 65, 32'hAABB_C35A, 4, 56'h02_0302_EE000000, 32, 1);
    run(1, 1, 0, 32'h0000_1234, '0, 4'hF, 337, 32'h4433_2211, 7, 56'h03_1234_00000000, 56, 1);

    // Reset during bit 10 of an ibus read: no ack, bus idle next cycle, rdt cleared.
    @(posedge clk); #1;
    c = cycnt;
    i1_adr = 32'h0000_1234; i1_cyc = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    wb_rst = 1'b1; i1_cyc = 1'b0;
    @(posedge clk); #1;
    cmp("abort_ss", 64'(ss1), 64'(1));
    cmp("abort_sck", 64'(sck1), 64'(0));
    cmp("abort_mosi", 64'(mosi1), 64'(0));
    cmp("abort_rdt_i", 64'(i1_rdt), 64'(0));
    cmp("abort_cycle", 64'(cycnt - c), 64'(22));
    wb_rst = 1'b0;
    repeat (3) @(posedge clk);

    // Contention after reset: ibus first, then dbus beats a re-requesting ibus.
    @(posedge clk); #1;
    mosi_log.delete(); sck_rises = 0; ss_falls = 0;
    c = cycnt;
    i1_adr = 32'h0000_1234; i1_cyc = 1'b1;
    d1_adr = 32'h0000_0100; d1_we = 1'b0; d1_sel = 4'hF; d1_cyc = 1'b1;
    q_i1.push_back(mk(c + 113, 32'h4433_2211, 7, 56'h03_1234_00000000, 56, 1));
    q_d1.push_back(mk(c + 228, 32'hAABB_C35A, 7, 56'h03_0100_00000000, 56, 2));
    q_i1.push_back(mk(c + 343, 32'hAABB_C35A, 7, 56'h03_0100_00000000, 56, 3));
    @(posedge clk); #1;
    i1_adr = 32'h0000_0100;
    repeat (228) @(posedge clk);
    #1;
    d1_cyc = 1'b0;
    repeat (115) @(posedge clk);
    #1;
    i1_cyc = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    cmp("pending_u1_ibus", 64'(q_i1.size()), 64'(0));
    cmp("pending_u1_dbus", 64'(q_d1.size()), 64'(0));
    cmp("pending_u3_dbus", 64'(q_d3.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
